// File: rtl/pc_phase_sequencer_pkg.sv
// Shared types and constants for the PC/phase sequencer: state codes, reset
// level, PC increment and the next-PC select helper.
package pc_phase_sequencer_pkg;

  localparam logic RST_VAL = 1'b0;
  localparam int PC_INCREMENT = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR = 32'h8000_0100;

  typedef enum logic {
    SEQ_FETCH = 1'b0,
    SEQ_EXEC  = 1'b1
  } seq_state_t;

  typedef enum logic [1:0] {
    NPC_SEQ      = 2'd0,
    NPC_REDIRECT = 2'd1,
    NPC_TRAP     = 2'd2
  } npc_sel_t;

  // Only word-aligned redirect targets are taken; anything else traps.
  function automatic npc_sel_t npc_select(input logic redirect_valid,
                                          input logic [1:0] target_lsb);
    npc_sel_t sel;
    if (!redirect_valid) sel = NPC_SEQ;
    else if (target_lsb == 2'b00) sel = NPC_REDIRECT;
    else sel = NPC_TRAP;
    return sel;
  endfunction

endpackage

// File: rtl/pc_phase_sequencer_phase_counter.sv
// Execute-phase counter: loads 1 when a fetch completes, advances while enabled,
// and returns to 0 on commit. 'last' marks the commit phase.
module pc_phase_sequencer_phase_counter
  import pc_phase_sequencer_pkg::*;
#(
  parameter int PHASES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] phase,
  output logic       last
);

  localparam logic [2:0] LAST_PHASE = 3'(PHASES - 1);

  assign last = (phase == LAST_PHASE);

  always_ff @(posedge clk) begin
    if (rst == RST_VAL) begin
      phase <= 3'd0;
    end else if (clr) begin
      phase <= 3'd0;
    end else if (start) begin
      phase <= 3'd1;
    end else if (en && !last) begin
      phase <= phase + 3'd1;
    end
  end

endmodule

// File: rtl/pc_phase_sequencer.sv
// PC and phase sequencer for the multi-cycle RV32E core: handshaked fetch,
// PHASES-1 execute phases, write-back strobe, and next-PC commit with trap.
module pc_phase_sequencer
  import pc_phase_sequencer_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              PHASES       = 3,
  parameter int              WB_PHASE     = 1,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic             ifetch_req,
  input  logic             ifetch_ack,
  input  logic [31:0]      inst_in,
  output logic [31:0]      inst,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [2:0]       phase,
  output logic             wb_strobe,
  output logic             retire,
  output logic             misalign,
  output logic [XLEN-1:0]  bad_addr,
  output logic [CNT_W-1:0] retire_cnt,
  output seq_state_t       seq_state
);

  if (PHASES < 2 || PHASES > 8 || WB_PHASE < 1 || WB_PHASE >= PHASES) begin : g_bad_params
    $error("pc_phase_sequencer: illegal PHASES=%0d / WB_PHASE=%0d", PHASES, WB_PHASE);
  end

  localparam logic [2:0] WB_P = 3'(WB_PHASE);

  seq_state_t      state, state_next;
  logic            running;
  logic            exec;
  logic            fetch_ack;
  logic            last;
  logic            commit;
  logic            trap;
  logic [XLEN-1:0] pc_next;

  // Every pulse is gated by reset so a reset edge never doubles as a fetch or commit.
  assign running   = (rst != RST_VAL);
  assign exec      = (state == SEQ_EXEC);
  assign seq_state = state;

  assign ifetch_req = (state == SEQ_FETCH) & running;
  assign fetch_ack  = ifetch_req & ifetch_ack;
  assign commit     = exec & last & ~stall & running;
  assign trap       = redirect_valid & (redirect_target[1:0] != 2'b00);

  assign wb_strobe = exec & (phase == WB_P) & ~stall & running;
  assign retire    = commit;
  assign misalign  = commit & trap;
  assign pc_plus4  = pc + XLEN'(PC_INCREMENT);

  pc_phase_sequencer_phase_counter #(
    .PHASES(PHASES)
  ) u_phase_counter (
    .clk  (clk),
    .rst  (rst),
    .start(fetch_ack),
    .en   (exec & ~stall),
    .clr  (commit),
    .phase(phase),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_VAL) state <= SEQ_FETCH;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SEQ_FETCH: if (fetch_ack) state_next = SEQ_EXEC;
      SEQ_EXEC:  if (commit)    state_next = SEQ_FETCH;
      default:                  state_next = SEQ_FETCH;
    endcase
  end

  always_comb begin
    pc_next = pc_plus4;
    case (npc_select(redirect_valid, redirect_target[1:0]))
      NPC_SEQ:      pc_next = pc_plus4;
      NPC_REDIRECT: pc_next = redirect_target;
      NPC_TRAP:     pc_next = TRAP_VECTOR;
      default:      pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_VAL) begin
      pc         <= RESET_VECTOR;
      inst       <= 32'd0;
      bad_addr   <= '0;
      retire_cnt <= '0;
    end else begin
      if (fetch_ack) inst <= inst_in;
      if (commit) begin
        pc         <= pc_next;
        retire_cnt <= retire_cnt + CNT_W'(1);
        if (trap) bad_addr <= redirect_target;
      end
    end
  end

endmodule

// File: tb/tb_pc_phase_sequencer.sv
// Directed bench for pc_phase_sequencer: a PHASES=3 instance driven step by step
// and a PHASES=2, CNT_W=2 instance checked for coincident wb/retire and count wrap.
module tb_pc_phase_sequencer;
  import pc_phase_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ifetch_ack;
  logic [31:0] inst_in;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  logic        ifetch_req, wb_strobe, retire, misalign;
  logic [31:0] inst, pc, pc_plus4, bad_addr, retire_cnt;
  logic [2:0]  phase;
  seq_state_t  seq_state;

  logic        ack2, redir2;
  logic [31:0] target2;
  logic        ifetch_req2, wb_strobe2, retire2, misalign2;
  logic [31:0] inst2, pc2, pc_plus4_2, bad_addr2;
  logic [1:0]  retire_cnt2;
  logic [2:0]  phase2;
  seq_state_t  seq_state2;

  int checks = 0;
  int errors = 0;
  int req_cycles;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pc_phase_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ifetch_req(ifetch_req), .ifetch_ack(ifetch_ack),
    .inst_in(inst_in), .inst(inst),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .pc(pc), .pc_plus4(pc_plus4), .phase(phase),
    .wb_strobe(wb_strobe), .retire(retire), .misalign(misalign),
    .bad_addr(bad_addr), .retire_cnt(retire_cnt), .seq_state(seq_state)
  );

  pc_phase_sequencer #(.PHASES(2), .WB_PHASE(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall),
    .ifetch_req(ifetch_req2), .ifetch_ack(ack2),
    .inst_in(inst_in), .inst(inst2),
    .redirect_valid(redir2), .redirect_target(target2),
    .pc(pc2), .pc_plus4(pc_plus4_2), .phase(phase2),
    .wb_strobe(wb_strobe2), .retire(retire2), .misalign(misalign2),
    .bad_addr(bad_addr2), .retire_cnt(retire_cnt2), .seq_state(seq_state2)
  );

  // driver tasks: inputs change and outputs are sampled around the negedge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; ifetch_ack = 1'b0; inst_in = 32'd0;
    redirect_valid = 1'b0; redirect_target = 32'd0;
    ack2 = 1'b1; redir2 = 1'b0; target2 = 32'd0;

    // reset state
    tick();
    chk("rst_req", ifetch_req, 0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_phase", phase, 0);
    chk("rst_inst", inst, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_bad", bad_addr, 0);
    chk("rst_pulses", {wb_strobe, retire, misalign}, 0);
    chk("rst_state", seq_state, SEQ_FETCH);

    // back-to-back instructions, ack in the first request cycle
    rst = 1'b1; ifetch_ack = 1'b1; inst_in = 32'h1111_0001; #1;
    chk("t1_req", ifetch_req, 1);
    chk("t1_pc4", pc_plus4, 32'h8000_0004);
    tick();
    chk("t1_p1_phase", phase, 1);
    chk("t1_p1_inst", inst, 32'h1111_0001);
    chk("t1_p1_wb", wb_strobe, 1);
    chk("t1_p1_ret", retire, 0);
    chk("t1_p1_req", ifetch_req, 0);
    tick();
    chk("t1_p2_phase", phase, 2);
    chk("t1_p2_ret", retire, 1);
    chk("t1_p2_wb", wb_strobe, 0);
    chk("t1_p2_pc", pc, 32'h8000_0000);
    tick();
    chk("t1_pc1", pc, 32'h8000_0004);
    chk("t1_cnt1", retire_cnt, 1);
    chk("t1_f_phase", phase, 0);
    chk("t1_f_ret", retire, 0);
    tick(); tick();
    chk("t1_ret2", retire, 1);
    tick();
    chk("t1_pc2", pc, 32'h8000_0008);
    chk("t1_cnt2", retire_cnt, 2);

    // ack delayed four cycles
    ifetch_ack = 1'b0; inst_in = 32'h2222_0002;
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (ifetch_req) req_cycles++;
      chk("t2_wait_pc", pc, 32'h8000_0008);
      chk("t2_wait_inst", inst, 32'h1111_0001);
      tick();
    end
    ifetch_ack = 1'b1; #1;
    if (ifetch_req) req_cycles++;
    chk("t2_req_cycles", req_cycles, 5);
    tick();
    chk("t2_inst", inst, 32'h2222_0002);
    chk("t2_phase", phase, 1);
    chk("t2_wb", wb_strobe, 1);

    // stall at the write-back phase; ack and redirect outside fetch/commit ignored
    inst_in = 32'h3333_0003; stall = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h8000_0080; #1;
    chk("t3_stall_wb", wb_strobe, 0);
    chk("t3_stall_ret", retire, 0);
    tick();
    chk("t3_s1_phase", phase, 1);
    chk("t3_s1_inst", inst, 32'h2222_0002);
    chk("t3_s1_wb", wb_strobe, 0);
    tick();
    chk("t3_s2_phase", phase, 1);
    chk("t3_s2_pc", pc, 32'h8000_0008);
    stall = 1'b0; #1;
    chk("t3_rel_wb", wb_strobe, 1);
    chk("t3_rel_ret", retire, 0);
    tick();
    chk("t4_p2_phase", phase, 2);
    chk("t4_p2_wb", wb_strobe, 0);
    chk("t4_p2_pc", pc, 32'h8000_0008);
    redirect_target = 32'h8000_0040; #1;
    chk("t4_commit_ret", retire, 1);
    chk("t4_commit_mis", misalign, 0);
    tick();
    chk("t4_pc", pc, 32'h8000_0040);
    chk("t4_cnt", retire_cnt, 3);
    redirect_valid = 1'b0;
    tick();
    chk("t4_inst_next", inst, 32'h3333_0003);

    // misaligned redirect traps
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h8000_0042; #1;
    chk("t5_mis", misalign, 1);
    chk("t5_ret", retire, 1);
    tick();
    chk("t5_pc", pc, 32'h8000_0100);
    chk("t5_bad", bad_addr, 32'h8000_0042);
    chk("t5_cnt", retire_cnt, 4);
    chk("t5_mis_drop", misalign, 0);
    redirect_valid = 1'b0;

    // pc_plus4 wraps at the top of the address space
    tick(); tick();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    chk("t5_wrap_pc", pc, 32'hFFFF_FFFC);
    chk("t5_wrap_pc4", pc_plus4, 0);
    chk("t5_wrap_bad", bad_addr, 32'h8000_0042);
    redirect_valid = 1'b0;

    // reset during the commit phase
    tick();
    chk("t6_p1", phase, 1);
    tick();
    chk("t6_p2", phase, 2);
    rst = 1'b0; #1;
    chk("t6_rst_ret", retire, 0);
    chk("t6_rst_wb", wb_strobe, 0);
    tick();
    chk("t6_pc", pc, 32'h8000_0000);
    chk("t6_phase", phase, 0);
    chk("t6_cnt", retire_cnt, 0);
    chk("t6_inst", inst, 0);
    chk("t6_bad", bad_addr, 0);
    chk("t6_req", ifetch_req, 0);

    // two-phase build: wb and retire coincide, narrow counter wraps
    rst = 1'b1; #1;
    chk("p2_req", ifetch_req2, 1);
    chk("p2_pc0", pc2, 32'h8000_0000);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("p2_wb_%0d", k), wb_strobe2, (k % 2));
      chk($sformatf("p2_ret_%0d", k), retire2, (k % 2));
      chk($sformatf("p2_cnt_%0d", k), retire_cnt2, (k / 2) % 4);
      chk($sformatf("p2_pc_%0d", k), pc2, 32'h8000_0000 + 4 * (k / 2));
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
